// File: rtl/multicore_pkg.sv
// multicore_pkg: arbitration modes, sequencer states and index-width helpers for multicore_ctrl
package multicore_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  typedef enum logic {ST_RELEASE, ST_DONE} st_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int idx_w(input int n);
    return clog2(n) < 1 ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/mc_arbiter.sv
// mc_arbiter: combinational fixed-priority or round-robin arbiter with one-hot grant and multi-request flag
module mc_arbiter
  import multicore_pkg::*;
#(
  parameter int N = 4,
  parameter int MODE = ARB_FIXED,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             multi
);
  assign multi = $countones(req) > 1;
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      j = MODE == ARB_RR ? (int'(ptr) + i) % N : i;
      if (grant == '0 && req[j]) begin
        grant[j] = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/multicore_ctrl.sv
// multicore_ctrl: staggered reset release for a core array plus a registered, arbitrated output collector
module multicore_ctrl
  import multicore_pkg::*;
#(
  parameter int N_CORES = 25,
  parameter int DATA_W = 28,
  parameter int EN_W = 4,
  parameter int STAGGER = 17,
  parameter int ARB_MODE = 0,
  localparam int IDX_W = idx_w(N_CORES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic [N_CORES*DATA_W-1:0] core_out,
  input  logic [N_CORES*EN_W-1:0]   core_en,
  output logic [N_CORES-1:0]        core_rst,
  output logic [DATA_W-1:0]         out_data,
  output logic [EN_W-1:0]           out_en,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_valid,
  output logic                      collision,
  output logic                      seq_done
);
  st_e state;
  logic [31:0] t;
  logic [IDX_W-1:0] ptr, win_idx;
  logic [N_CORES-1:0] elig, grant;
  logic [DATA_W-1:0] win_data;
  logic [EN_W-1:0] win_en;
  logic multi, take;
  // an accepted restart masks every core on the same edge core_rst rises
  assign take = state == ST_DONE && restart;
  always_comb begin
    elig = '0;
    for (int k = 0; k < N_CORES; k++)
      elig[k] = !core_rst[k] && core_en[k*EN_W +: EN_W] != '0 && !take;
  end
  mc_arbiter #(.N(N_CORES), .MODE(ARB_MODE)) arb (
    .req(elig), .ptr(ptr), .grant(grant), .idx(win_idx), .multi(multi)
  );
  always_comb begin
    win_data = '0;
    win_en = '0;
    for (int k = 0; k < N_CORES; k++)
      if (grant[k]) begin
        win_data = core_out[k*DATA_W +: DATA_W];
        win_en = core_en[k*EN_W +: EN_W];
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst <= '1;
      out_data <= '0;
      out_en <= '0;
      out_idx <= '0;
      out_valid <= 1'b0;
      collision <= 1'b0;
      seq_done <= 1'b0;
      t <= '0;
      ptr <= '0;
      state <= ST_RELEASE;
    end else begin
      out_valid <= |grant;
      out_data <= win_data;
      out_en <= win_en;
      out_idx <= win_idx;
      collision <= multi;
      if (|grant && ARB_MODE == ARB_RR)
        ptr <= win_idx == IDX_W'(N_CORES - 1) ? '0 : win_idx + 1'b1;
      if (state == ST_RELEASE) begin
        if (core_rst == '0) begin
          state <= ST_DONE;
          seq_done <= 1'b1;
        end else begin
          t <= t + 1;
          for (int k = 0; k < N_CORES; k++)
            if (t == 32'(k * STAGGER)) core_rst[k] <= 1'b0;
        end
      end else if (restart) begin
        core_rst <= '1;
        seq_done <= 1'b0;
        t <= '0;
        state <= ST_RELEASE;
      end
    end
  end
endmodule

// File: tb/tb_multicore_ctrl.sv
// tb_multicore_ctrl: directed vectors for release timing, fixed/round-robin arbitration, restart and async reset
module tb_multicore_ctrl;
  localparam int N = 4, DW = 28, EW = 4;
  logic clk = 0, rst = 1, restart = 0;
  logic [N*DW-1:0] core_out = '0;
  logic [N*EW-1:0] core_en = '0;
  logic [N-1:0] r0, r1;
  logic [DW-1:0] d0, d1;
  logic [EW-1:0] e0, e1;
  logic [1:0] i0, i1;
  logic v0, v1, c0, c1, s0, s1;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [N*EW-1:0] en;
    logic [N*DW-1:0] dat;
    logic v;
    logic [1:0] idx;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic c;
  } vec_t;
  vec_t tbl[6];
  logic [3:0] rel_rst[11];

  multicore_ctrl #(.N_CORES(N), .DATA_W(DW), .EN_W(EW), .STAGGER(3), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .restart(restart), .core_out(core_out), .core_en(core_en),
    .core_rst(r0), .out_data(d0), .out_en(e0), .out_idx(i0), .out_valid(v0),
    .collision(c0), .seq_done(s0)
  );
  multicore_ctrl #(.N_CORES(N), .DATA_W(DW), .EN_W(EW), .STAGGER(3), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .restart(restart), .core_out(core_out), .core_en(core_en),
    .core_rst(r1), .out_data(d1), .out_en(e1), .out_idx(i1), .out_valid(v1),
    .collision(c1), .seq_done(s1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // edges 1..11 of a release sequence; restart at edge 5 must be ignored
  task automatic run_seq(input bit en_on);
    for (int e = 1; e <= 11; e++) begin
      restart = (e == 5);
      step();
      restart = 0;
      chk($sformatf("rst0_e%0d", e), 64'(r0), 64'(rel_rst[e-1]));
      chk($sformatf("rst1_e%0d", e), 64'(r1), 64'(rel_rst[e-1]));
      chk($sformatf("done_e%0d", e), 64'(s0), 64'(e == 11));
      if (en_on) begin
        chk($sformatf("mval_e%0d", e), 64'(v0), 64'(e >= 2));
        chk($sformatf("midx_e%0d", e), 64'(i0), 64'd0);
        chk($sformatf("mcol_e%0d", e), 64'(c0), 64'(e >= 5));
        if (e <= 10) chk($sformatf("rr_no3_e%0d", e), 64'(i1 == 2'd3), 64'd0);
      end
    end
  endtask

  initial begin
    rel_rst = '{4'hE, 4'hE, 4'hE, 4'hC, 4'hC, 4'hC, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    tbl[0] = '{16'h0110, {28'h0, 28'hFFFFFFB, 28'h0000123, 28'h0}, 1, 2'd1, 28'h0000123, 4'h1, 1};
    tbl[1] = '{16'h8000, {28'h8000001, 28'h5, 28'h6, 28'h7}, 1, 2'd3, 28'h8000001, 4'h8, 0};
    tbl[2] = '{16'h0000, {4{28'hAAAAAAA}}, 0, 2'd0, 28'h0, 4'h0, 0};
    tbl[3] = '{16'h5432, {28'h4, 28'h3, 28'h2, 28'hFFFFFFF}, 1, 2'd0, 28'hFFFFFFF, 4'h2, 1};
    tbl[4] = '{16'h0F00, {28'h1, 28'hFFFFFFB, 28'h2, 28'h3}, 1, 2'd2, 28'hFFFFFFB, 4'hF, 0};
    tbl[5] = '{16'hF0F0, {28'h0ABCDEF, 28'h1, 28'h7654321, 28'h2}, 1, 2'd1, 28'h7654321, 4'hF, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_core_rst", 64'(r0), 64'hF);
    chk("reset_valid", 64'(v0), 64'd0);
    chk("reset_done", 64'(s0), 64'd0);
    chk("reset_data", 64'(d0), 64'd0);
    chk("reset_idx", 64'(i1), 64'd0);
    rst = 0;
    run_seq(0);
    for (int i = 0; i < 6; i++) begin
      core_en = tbl[i].en;
      core_out = tbl[i].dat;
      step();
      chk($sformatf("t%0d_valid", i), 64'(v0), 64'(tbl[i].v));
      chk($sformatf("t%0d_idx", i), 64'(i0), 64'(tbl[i].idx));
      chk($sformatf("t%0d_data", i), 64'(d0), 64'(tbl[i].d));
      chk($sformatf("t%0d_en", i), 64'(e0), 64'(tbl[i].e));
      chk($sformatf("t%0d_coll", i), 64'(c0), 64'(tbl[i].c));
    end
    core_en = 16'h1111;
    step();
    chk("pre_restart_valid", 64'(v0), 64'd1);
    restart = 1;
    step();
    restart = 0;
    chk("restart_core_rst", 64'(r0), 64'hF);
    chk("restart_done", 64'(s0), 64'd0);
    chk("restart_valid0", 64'(v0), 64'd0);
    chk("restart_valid1", 64'(v1), 64'd0);
    run_seq(1);
    restart = 1;
    step();
    restart = 0;
    step();
    step();
    chk("pre_async_valid", 64'(v0), 64'd1);
    #3 rst = 1;
    #1;
    chk("async_core_rst", 64'(r0), 64'hF);
    chk("async_valid", 64'(v0), 64'd0);
    chk("async_idx1", 64'(v1), 64'd0);
    chk("async_done", 64'(s0), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    core_en = '0;
    run_seq(0);
    core_en = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr%0d_idx", i), 64'(i1), 64'(i % 4));
      chk($sformatf("rr%0d_coll", i), 64'(c1), 64'd1);
      chk($sformatf("rr%0d_valid", i), 64'(v1), 64'd1);
      chk($sformatf("fx%0d_idx", i), 64'(i0), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
